// File: rtl/prio_arbiter.sv
// Single-grant arbiter: fixed-priority (MODE=0, highest index wins) or round-robin (MODE=1).
// A grant is held until the owner drops its request or pulses done; one IDLE cycle follows every release.
module prio_arbiter #(
  parameter  int N    = 4,
  parameter  int MODE = 0,
  localparam int IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_onehot
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]  gnt_onehot_q, gnt_onehot_d;

  logic [IW-1:0] win_fp, win_any, win_hi, winner;
  logic          hi_found;
  logic          grant, release_own;

  // Round-robin: lowest set bit at or above ptr, else lowest set bit overall (the wrap).
  always_comb begin
    win_fp   = '0;
    win_any  = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) win_fp = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) win_any = IW'(i);
      if (req[i] && i >= int'(ptr_q)) begin
        win_hi   = IW'(i);
        hi_found = 1'b1;
      end
    end
    winner = (MODE == 1) ? (hi_found ? win_hi : win_any) : win_fp;
  end

  assign grant       = (state_q == IDLE) && (|req);
  assign release_own = (state_q == BUSY) && (done || !req[gnt_idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (release_own) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    if (grant) begin
      gnt_valid_d  = 1'b1;
      gnt_idx_d    = winner;
      gnt_onehot_d = N'(1) << winner;
      if (MODE == 1) ptr_d = (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
    end else if (release_own) begin
      // gnt_idx keeps the last owner after release
      gnt_valid_d  = 1'b0;
      gnt_onehot_d = '0;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: fixed-priority and round-robin instances driven in lockstep,
// checked each edge against a queue-free arithmetic model, plus directed scenario checks.
module tb_prio_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, done;
  logic [N-1:0]  req;
  logic          fp_valid, rr_valid;
  logic [IW-1:0] fp_idx, rr_idx;
  logic [N-1:0]  fp_oh, rr_oh;

  int errors = 0;
  int checks = 0;

  // model state per instance: 0 = fixed priority, 1 = round robin
  int m_valid[2];
  int m_idx[2];
  int m_ptr[2];

  prio_arbiter #(.N(N), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_valid(fp_valid), .gnt_idx(fp_idx), .gnt_onehot(fp_oh)
  );

  prio_arbiter #(.N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_valid(rr_valid), .gnt_idx(rr_idx), .gnt_onehot(rr_oh)
  );

  // fixed: floor(log2(req)); round robin: rotate by ptr, count trailing zeros
  function automatic int winner(int mode, int p, logic [N-1:0] r);
    logic [2*N-1:0] dbl;
    int k;
    if (mode == 0) return $clog2(int'(r) + 1) - 1;
    dbl = {r, r} >> p;
    k = 0;
    while (!dbl[k]) k++;
    return (p + k) % N;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 0;
      end else if (m_valid[m] != 0) begin
        if (done || !req[m_idx[m]]) m_valid[m] = 0;
      end else if (req != '0) begin
        m_idx[m]   = winner(m, m_ptr[m], req);
        m_valid[m] = 1;
        if (m == 1) m_ptr[m] = (m_idx[m] + 1) % N;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fp_valid", 32'(fp_valid), 32'(m_valid[0]));
    chk("fp_idx",   32'(fp_idx),   32'(m_idx[0]));
    chk("fp_oh",    32'(fp_oh),    (m_valid[0] != 0) ? (32'd1 << m_idx[0]) : 32'd0);
    chk("rr_valid", 32'(rr_valid), 32'(m_valid[1]));
    chk("rr_idx",   32'(rr_idx),   32'(m_idx[1]));
    chk("rr_oh",    32'(rr_oh),    (m_valid[1] != 0) ? (32'd1 << m_idx[1]) : 32'd0);
    chk("rr_ptr",   32'(u_rr.ptr_q), 32'(m_ptr[1]));
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] rq;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 0;
    end
    rst = 1'b1; req = '0; done = 1'b0;

    // reset state
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1);
    chk("rst_valid", 32'(fp_valid), 32'd0);
    chk("rst_oh",    32'(rr_oh),    32'd0);

    // fixed priority picks highest set bit, one-edge latency
    cyc(1'b0, 4'b0110, 1'b0);
    chk("r028_valid", 32'(fp_valid), 32'd1);
    chk("r028_idx",   32'(fp_idx),   32'd2);
    chk("r028_oh",    32'(fp_oh),    32'b0100);
    chk("r028_rr_idx", 32'(rr_idx),  32'd1);

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0000, 1'b0);
      chk("r029_valid", 32'(fp_valid), 32'd0);
      chk("r029_oh",    32'(fp_oh),    32'd0);
    end

    // round robin rotation with done pulses
    cyc(1'b1, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      cyc(1'b0, 4'b1111, 1'b0);
      chk("r030_valid", 32'(rr_valid), 32'd1);
      chk("r030_idx",   32'(rr_idx),   32'(seq[g]));
      chk("r030_fp",    32'(fp_idx),   32'd3);
      cyc(1'b0, 4'b1111, 1'b1);
      chk("r030_gap",   32'(rr_valid), 32'd0);
    end

    // pointer wrap
    cyc(1'b0, 4'b0100, 1'b0);
    chk("r031_idx2", 32'(rr_idx),      32'd2);
    chk("r031_ptr3", 32'(u_rr.ptr_q),  32'd3);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0011, 1'b0);
    chk("r031_wrap", 32'(rr_idx),      32'd0);
    chk("r031_ptr1", 32'(u_rr.ptr_q),  32'd1);
    chk("r031_fp",   32'(fp_idx),      32'd1);

    // owner drop, then done in IDLE ignored
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    chk("r032_own", 32'(rr_idx), 32'd1);
    cyc(1'b0, 4'b0000, 1'b0);
    chk("r032_drop_v", 32'(rr_valid), 32'd0);
    chk("r032_drop_i", 32'(rr_idx),   32'd1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("r032_done_v", 32'(fp_valid), 32'd0);
    chk("r032_done_i", 32'(fp_idx),   32'd1);

    // reset mid-BUSY beats done, then re-grant
    cyc(1'b0, 4'b1000, 1'b0);
    chk("r033_busy", 32'(rr_idx), 32'd3);
    cyc(1'b1, 4'b1000, 1'b1);
    chk("r033_rst_v", 32'(rr_valid),    32'd0);
    chk("r033_rst_i", 32'(rr_idx),      32'd0);
    chk("r033_rst_p", 32'(u_rr.ptr_q),  32'd0);
    cyc(1'b0, 4'b1000, 1'b0);
    chk("r033_regnt", 32'(fp_idx),   32'd3);
    chk("r033_rr",    32'(rr_idx),   32'd3);

    // random traffic; often keep current bits so grants live several cycles
    for (int i = 0; i < 400; i++) begin
      rq = 4'($urandom);
      if ($urandom_range(0, 1) == 1) rq = req | rq;
      cyc(($urandom_range(0, 31) == 0), rq, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N, default 4: number of request channels; legal range 2..32.
REQ-002 Parameter MODE, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-003 Derived width IW = clog2(N): width of the grant index.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port req, input, N bits: request lines; bit i high means channel i requests.
REQ-007 Port done, input, 1 bit: the current owner releases the grant.
REQ-008 Port gnt_valid, output, 1 bit, registered: a grant is active.
REQ-009 Port gnt_idx, output, IW bits, registered: binary index of the granted channel.
REQ-010 Port gnt_onehot, output, N bits, registered: one-hot grant vector; all zero when gnt_valid=0.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-012 IDLE -> BUSY: when req != 0 at a clock edge; gnt_valid, gnt_idx and gnt_onehot SHALL update on that same edge, giving 1-cycle latency from req to grant.
REQ-013 IDLE with req == 0: stay in IDLE; outputs unchanged.
REQ-014 MODE=0 winner: the highest-index set bit of req (channel N-1 has the highest priority).
REQ-015 MODE=1 winner: the first set bit found scanning upward from internal pointer ptr (IW bits), wrapping N-1 -> 0.
REQ-016 MODE=1 pointer update: on each IDLE -> BUSY transition, ptr SHALL become (winner+1) mod N; otherwise ptr holds.
REQ-017 MODE=0: ptr is unused; its value SHALL have no effect on any output.
REQ-018 BUSY: grant outputs SHALL hold stable and SHALL ignore changes on req lines other than req[gnt_idx].
REQ-019 BUSY -> IDLE: at an edge where done=1 or req[gnt_idx]=0 (owner drop). The same edge SHALL clear gnt_valid and gnt_onehot; gnt_idx SHALL retain its last value.
REQ-020 After every release, exactly one IDLE cycle SHALL occur before the next grant; there are no back-to-back grants.
REQ-021 done sampled in IDLE SHALL be ignored.
REQ-022 Simultaneous done=1 and owner drop SHALL be treated as a single release.
REQ-023 gnt_onehot SHALL equal (1 << gnt_idx) whenever gnt_valid=1.
REQ-024 At most one grant SHALL be active at any time.

Reset
REQ-025 rst=1 at an edge SHALL force: state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0.
REQ-026 rst SHALL take priority over all other inputs, including mid-BUSY and on the same edge as done.
REQ-027 After rst falls, arbitration SHALL resume normally; the first grant occurs on the first edge where rst=0 and req != 0.

Verification (N=4)
REQ-028 MODE=0, req=0110 from IDLE -> one edge later gnt_valid=1, gnt_idx=2, gnt_onehot=0100.
REQ-029 MODE=0, req=0000 held for 10 cycles -> gnt_valid stays 0 and gnt_onehot stays 0000 throughout.
REQ-030 MODE=1, req=1111 held, done pulsed one cycle after each grant -> grant sequence 0,1,2,3,0, with one IDLE cycle between grants.
REQ-031 MODE=1, ptr=3 after a grant to channel 2, then req=0011 -> grant to channel 0 (wrap), after which ptr=1.
REQ-032 BUSY with owner 1, req[1] dropped -> next edge gnt_valid=0 and gnt_idx stays 1; a following done pulse in IDLE produces no change.
REQ-033 rst=1 in BUSY with req=1000 held -> next edge all outputs 0 and ptr=0; after rst falls, gnt_idx=3 appears one edge later.
